// File: rtl/sseg_score_scan.sv
// -----------------------------------------------------------------------------
// sseg_score_scan
//   Converts the binary game score to BCD with a sequential double-dabble
//   engine (one bit per clock). It then time-multiplexes the four BCD digits
//   onto the board's common-anode seven-segment display.
//
//   Ports
//     sys_clk       in   1       system clock (50 MHz)
//     reset         in   1       asynchronous, active-high reset
//     data          in   DATA_W  binary score, unsigned
//     bcd_out       out  16      {thousands, hundreds, tens, units}
//     busy          out  1       high while a conversion is in progress
//     sseg_a_to_dp  out  8       segments, active-low, bit0 = a .. bit6 = g, bit7 = dp
//     sseg_an       out  4       anodes, active-low, an[0] = units digit
//
//   Latency: counting the edge at which IDLE samples new data as edge 1,
//   bcd_out takes the new value on edge DATA_W+2. The segments follow one
//   edge later.
// -----------------------------------------------------------------------------
module sseg_score_scan #(
  parameter int DATA_W      = 8,      // 4..16
  parameter int REFRESH_DIV = 50000,  // sys_clk cycles per digit slot, >= 2
  parameter int BLANK_LZ    = 1       // 1 = blank leading zeros
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       bcd_out,
  output logic              busy,
  output logic [7:0]        sseg_a_to_dp,
  output logic [3:0]        sseg_an
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [4:0]       LAST_BIT = 5'(DATA_W - 1);
  localparam int               REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_TC   = REF_W'(REFRESH_DIV - 1);

  // Converter state
  logic [1:0]        state_q,   state_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic [DATA_W-1:0] last_q,    last_d;
  logic [15:0]       acc_q,     acc_d;
  logic [15:0]       bcd_out_q, bcd_out_d;
  logic [4:0]        bitcnt_q,  bitcnt_d;
  logic              pend_q,    pend_d;
  logic              busy_q,    busy_d;
  logic              ovf_q,     ovf_d;

  // Scan state
  logic [REF_W-1:0]  ref_q,     ref_d;
  logic [1:0]        idx_q,     idx_d;
  logic [3:0]        an_q,      an_d;
  logic [7:0]        seg_q,     seg_d;

  logic [15:0]       adj;
  logic [3:0]        lit;
  logic [3:0]        digit;

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'd0:    seg_lut = 8'hC0;
      4'd1:    seg_lut = 8'hF9;
      4'd2:    seg_lut = 8'hA4;
      4'd3:    seg_lut = 8'hB0;
      4'd4:    seg_lut = 8'h99;
      4'd5:    seg_lut = 8'h92;
      4'd6:    seg_lut = 8'h82;
      4'd7:    seg_lut = 8'hF8;
      4'd8:    seg_lut = 8'h80;
      4'd9:    seg_lut = 8'h90;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    acc_d     = acc_q;
    bcd_out_d = bcd_out_q;
    bitcnt_d  = bitcnt_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        // Re-comparing against last_q here is what catches updates that
        // arrived while a conversion was running.
        if (pend_q || (data != last_q)) begin
          shreg_d  = data;
          last_d   = data;
          acc_d    = 16'h0000;
          bitcnt_d = 5'd0;
          pend_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d    = {adj[14:0], shreg_q[DATA_W-1]};
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 5'd1;
        if (bitcnt_q == LAST_BIT) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Only reachable for DATA_W >= 14; the fifth BCD digit was dropped.
        if (32'(last_q) > 32'd9999) begin
          ovf_d     = 1'b1;
          bcd_out_d = 16'h9999;
        end else begin
          ovf_d     = 1'b0;
          bcd_out_d = acc_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_TC) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // lit[k] is set when digit k or any higher digit is non-zero; the units
    // digit is always lit.
    lit[3] = (bcd_out_q[15:12] != 4'd0);
    lit[2] = lit[3] | (bcd_out_q[11:8] != 4'd0);
    lit[1] = lit[2] | (bcd_out_q[7:4]  != 4'd0);
    lit[0] = 1'b1;

    digit       = bcd_out_q[4*idx_q +: 4];
    an_d        = 4'b1111;
    an_d[idx_q] = 1'b0;

    if (ovf_q)                          seg_d = 8'hBF;
    else if (BLANK_LZ != 0 && !lit[idx_q]) seg_d = 8'hFF;
    else                                seg_d = seg_lut(digit);
  end

  // NOTE: pend_q resets to 1 so a conversion is forced right after reset, even
  // when data happens to equal the reset value of last_q.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      last_q    <= '0;
      acc_q     <= 16'h0000;
      bcd_out_q <= 16'h0000;
      bitcnt_q  <= 5'd0;
      pend_q    <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ref_q     <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      bcd_out_q <= bcd_out_d;
      bitcnt_q  <= bitcnt_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bcd_out      = bcd_out_q;
  assign busy         = busy_q;
  assign sseg_an      = an_q;
  assign sseg_a_to_dp = seg_q;

endmodule
